// File: rtl/fwd_pkg.sv
// Shared forwarding select encodings and the shadow-pipeline slot tag.
package fwd_pkg;

    localparam int unsigned TAG_RD_W = 5;

    localparam logic [1:0] FWD_REG   = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

    typedef struct packed {
        logic                valid;
        logic [TAG_RD_W-1:0] rd;
        logic                reg_write;
        logic                mem_read;
    } stage_tag_t;

endpackage

// File: rtl/fwd_match.sv
// Compares one source register against the EX and MEM slot tags and returns its select code.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned SEL_W      = 2
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic                  use_rs,
    input  stage_tag_t            ex_tag,
    input  stage_tag_t            mem_tag,
    output logic [SEL_W-1:0]      sel
);

    logic ex_hit;
    logic mem_hit;

    // x0 never forwards; the WB slot is covered by the write-before-read register file.
    assign ex_hit  = ex_tag.valid  && ex_tag.reg_write  && (ex_tag.rd  != '0) && (ex_tag.rd  == rs);
    assign mem_hit = mem_tag.valid && mem_tag.reg_write && (mem_tag.rd != '0) && (mem_tag.rd == rs);

    always_comb begin
        sel = SEL_W'(FWD_REG);
        if (use_rs) begin
            if (ex_hit) begin
                sel = SEL_W'(FWD_EXMEM);
            end else if (mem_hit) begin
                sel = SEL_W'(FWD_MEMWB);
            end
        end
    end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// EX operand forwarding selects and load-use stall control, driven by a shadow pipeline of destination tags.
module forwarding_hazard_unit
    import fwd_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned SEL_W      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  ex_branch_taken,
    input  logic                  mem_busy,
    output logic [SEL_W-1:0]      fwd_a_sel,
    output logic [SEL_W-1:0]      fwd_b_sel,
    output logic                  stall,
    output logic                  ex_bubble
);

    stage_tag_t ex_q, mem_q, wb_q;
    stage_tag_t id_tag;
    logic [SEL_W-1:0] fwd_a_q, fwd_b_q;
    logic [SEL_W-1:0] fwd_a_d, fwd_b_d;
    logic             id_live;
    logic             load_use;

    assign id_live = id_valid && !ex_branch_taken;

    always_comb begin
        id_tag           = '0;
        id_tag.valid     = id_live;
        id_tag.rd        = TAG_RD_W'(id_rd);
        id_tag.reg_write = id_reg_write;
        id_tag.mem_read  = id_mem_read;
    end

    assign load_use = !rst && id_live && ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) &&
                      ((id_use_rs1 && (TAG_RD_W'(id_rs1) == ex_q.rd)) ||
                       (id_use_rs2 && (TAG_RD_W'(id_rs2) == ex_q.rd)));

    assign stall     = !rst && (mem_busy || load_use);
    assign ex_bubble = !rst && !mem_busy && (load_use || ex_branch_taken);

    fwd_match #(.REG_ADDR_W(REG_ADDR_W), .SEL_W(SEL_W)) u_match_a (
        .rs      (id_rs1),
        .use_rs  (id_use_rs1),
        .ex_tag  (ex_q),
        .mem_tag (mem_q),
        .sel     (fwd_a_d)
    );

    fwd_match #(.REG_ADDR_W(REG_ADDR_W), .SEL_W(SEL_W)) u_match_b (
        .rs      (id_rs2),
        .use_rs  (id_use_rs2),
        .ex_tag  (ex_q),
        .mem_tag (mem_q),
        .sel     (fwd_b_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            fwd_a_q <= '0;
            fwd_b_q <= '0;
        end else if (!mem_busy) begin
            mem_q <= ex_q;
            wb_q  <= mem_q;
            // Load-use and squashed ID instructions both enter EX as a bubble with zero selects.
            if (load_use || !id_live) begin
                ex_q    <= '0;
                fwd_a_q <= '0;
                fwd_b_q <= '0;
            end else begin
                ex_q    <= id_tag;
                fwd_a_q <= fwd_a_d;
                fwd_b_q <= fwd_b_d;
            end
        end
    end

    assign fwd_a_sel = fwd_a_q;
    assign fwd_b_sel = fwd_b_q;

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed check of forwarding selects, load-use stalls, branch squash, memory freeze and reset.
module tb_forwarding_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_use_rs1, id_use_rs2;
    logic       id_reg_write, id_mem_read;
    logic       ex_branch_taken, mem_busy;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic       stall, ex_bubble;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    forwarding_hazard_unit #(.REG_ADDR_W(5), .SEL_W(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .id_rd           (id_rd),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .mem_busy        (mem_busy),
        .fwd_a_sel       (fwd_a_sel),
        .fwd_b_sel       (fwd_b_sel),
        .stall           (stall),
        .ex_bubble       (ex_bubble)
    );

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] a, input logic [1:0] b,
                           input logic st, input logic bub);
        chk({tag, ".a"},      fwd_a_sel, a);
        chk({tag, ".b"},      fwd_b_sel, b);
        chk({tag, ".stall"},  {1'b0, stall}, {1'b0, st});
        chk({tag, ".bubble"}, {1'b0, ex_bubble}, {1'b0, bub});
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                          input logic rw, input logic mr);
        id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
        id_rd = rd; id_reg_write = rw; id_mem_read = mr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; mem_busy = 1'b1; ex_branch_taken = 1'b0;
        set_id(1, 5'd1, 1, 5'd1, 1, 5'd1, 1, 1);
        tick(); tick();
        chk_all("reset", 2'd0, 2'd0, 1'b0, 1'b0);
        rst = 1'b0; mem_busy = 1'b0;

        // add x5 ; sub x6,x5,x7
        set_id(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0); tick();
        set_id(1, 5'd5, 1, 5'd7, 1, 5'd6, 1, 0);
        chk_all("b2b_id", 2'd0, 2'd0, 1'b0, 1'b0);
        tick();
        chk_all("b2b_ex", 2'd1, 2'd0, 1'b0, 1'b0);

        // add x5 ; xor x10,x11,x12 ; or x8,x9,x5
        set_id(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0); tick();
        set_id(1, 5'd11, 1, 5'd12, 1, 5'd10, 1, 0); tick();
        set_id(1, 5'd9, 1, 5'd5, 1, 5'd8, 1, 0); tick();
        chk_all("dist2", 2'd0, 2'd2, 1'b0, 1'b0);

        // add x5 ; addi x5,x13 ; or x8,x9,x5 -> nearest producer wins
        set_id(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0); tick();
        set_id(1, 5'd13, 1, 5'd0, 0, 5'd5, 1, 0); tick();
        set_id(1, 5'd9, 1, 5'd5, 1, 5'd8, 1, 0); tick();
        chk_all("prio", 2'd0, 2'd1, 1'b0, 1'b0);

        // lw x3 ; add x4,x3,x3
        set_id(1, 5'd2, 1, 5'd0, 0, 5'd3, 1, 1); tick();
        set_id(1, 5'd3, 1, 5'd3, 1, 5'd4, 1, 0);
        chk_all("lu_stall", 2'd0, 2'd0, 1'b1, 1'b1);
        tick();
        chk_all("lu_bubble", 2'd0, 2'd0, 1'b0, 1'b0);
        tick();
        chk_all("lu_ex", 2'd2, 2'd2, 1'b0, 1'b0);

        // add x0 ; sub x1,x0,x0
        set_id(1, 5'd1, 1, 5'd2, 1, 5'd0, 1, 0); tick();
        set_id(1, 5'd0, 1, 5'd0, 1, 5'd1, 1, 0); tick();
        chk_all("x0", 2'd0, 2'd0, 1'b0, 1'b0);

        // add x7 ; consumer reads x7 on rs1 only
        set_id(1, 5'd1, 1, 5'd2, 1, 5'd7, 1, 0); tick();
        set_id(1, 5'd7, 1, 5'd7, 0, 5'd9, 1, 0); tick();
        chk_all("unused", 2'd1, 2'd0, 1'b0, 1'b0);

        // lw x3 ; add x4,x3,x3 squashed by a taken branch
        set_id(1, 5'd2, 1, 5'd0, 0, 5'd3, 1, 1); tick();
        ex_branch_taken = 1'b1;
        set_id(1, 5'd3, 1, 5'd3, 1, 5'd4, 1, 0);
        chk_all("br_lu", 2'd0, 2'd0, 1'b0, 1'b1);
        tick();
        ex_branch_taken = 1'b0;
        set_id(1, 5'd3, 1, 5'd3, 1, 5'd4, 1, 0);
        chk_all("br_squash", 2'd0, 2'd0, 1'b0, 1'b0);
        tick();
        chk_all("br_next", 2'd2, 2'd2, 1'b0, 1'b0);

        // lw x3 (rs1=x4, forwarded from EX) ; dependent add frozen by mem_busy for 3 cycles
        set_id(1, 5'd4, 1, 5'd0, 0, 5'd3, 1, 1); tick();
        chk_all("busy_lw", 2'd1, 2'd0, 1'b0, 1'b0);
        mem_busy = 1'b1;
        set_id(1, 5'd3, 1, 5'd3, 1, 5'd4, 1, 0);
        for (int i = 0; i < 3; i++) begin
            chk_all("busy_hold", 2'd1, 2'd0, 1'b1, 1'b0);
            tick();
        end
        mem_busy = 1'b0;
        #1;
        chk_all("busy_rel", 2'd1, 2'd0, 1'b1, 1'b1);
        tick();
        chk_all("busy_bubble", 2'd0, 2'd0, 1'b0, 1'b0);
        tick();
        chk_all("busy_ex", 2'd2, 2'd2, 1'b0, 1'b0);

        // reset asserted mid load-use stall
        set_id(1, 5'd4, 1, 5'd0, 0, 5'd3, 1, 1); tick();
        set_id(1, 5'd3, 1, 5'd3, 1, 5'd4, 1, 0);
        chk_all("rst_pre", 2'd1, 2'd0, 1'b1, 1'b1);
        rst = 1'b1;
        #1;
        chk_all("rst_gate", 2'd1, 2'd0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        chk_all("rst_post", 2'd0, 2'd0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/forwarding_hazard_unit.md
# forwarding_hazard_unit

- Produces the 2-bit select codes for the EX-stage operand multiplexers (register file / EX-MEM result / MEM-WB result).
- Detects load-use hazards and drives the one-cycle stall and bubble.
- Tracks destination-register tags of in-flight instructions in its own shadow pipeline (EX, MEM, WB slots), kept in lockstep with the CPU pipeline.
- Sits beside the ID/EX pipeline register; its select outputs drive the operand muxes directly.

## Interface

Parameters:
- REG_ADDR_W, 5, register index width
- SEL_W, 2, forwarding select width (fixed encoding; see Structure)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- id_valid  input  1  ID holds a real instruction
- id_rs1, id_rs2  input  REG_ADDR_W  source registers of the ID instruction
- id_use_rs1, id_use_rs2  input  1  the ID instruction actually reads rs1/rs2
- id_rd  input  REG_ADDR_W  destination of the ID instruction
- id_reg_write  input  1  the ID instruction writes rd
- id_mem_read  input  1  the ID instruction is a load
- ex_branch_taken  input  1  redirect from EX; squash the ID instruction
- mem_busy  input  1  data memory not ready; whole pipeline frozen
- fwd_a_sel, fwd_b_sel  output  SEL_W  operand A/B select for the instruction currently in EX
- stall  output  1  hold PC and IF/ID this cycle
- ex_bubble  output  1  ID/EX loads a NOP at the next edge

## Operation

- Shadow slots EX, MEM and WB each hold {valid, rd, reg_write, mem_read}.
- Advance condition: mem_busy=0 and load-use=0. When it holds, EX←ID entry, MEM←EX and WB←MEM.
- The ID entry is invalid when id_valid=0 or ex_branch_taken=1.
- Load-use (combinational): EX.valid & EX.mem_read & EX.rd≠0 & ((id_use_rs1 & id_rs1==EX.rd) | (id_use_rs2 & id_rs2==EX.rd)) & id_valid & !ex_branch_taken.
  - On a load-use cycle, MEM←EX, WB←MEM and EX←invalid (the bubble).
- stall = mem_busy | load-use.
- ex_bubble = !mem_busy & (load-use | ex_branch_taken).
- Select computation: done for each operand when the ID entry advances, and registered into fwd_*_sel.
  - 2'd1 (EX-MEM) when the current EX slot is valid, reg_write=1, rd≠0 and rd==rs.
  - Otherwise 2'd2 (MEM-WB) when the current MEM slot matches under the same rules.
  - Otherwise 2'd0.
  - A source with use=0 always gets 0.
  - The register file is write-before-read, so the WB slot never forwards.
- Register x0 is never forwarded.
- A loaded value reaches EX only via 2'd2, because a load-use always inserts one bubble first.
- On a bubble, fwd_*_sel load 0.
- fwd_*_sel never take 2'd3.
- Priority of simultaneous events:
  - mem_busy=1 overrides everything: all slots and outputs hold. The CPU keeps ex_branch_taken asserted while frozen.
  - ex_branch_taken beats load-use: stall = mem_busy, and the squashed ID instruction enters EX as invalid.

## Timing

- Reset: all slot valid bits 0, fwd_a_sel = fwd_b_sel = 0. stall and ex_bubble are 0 while rst=1 (combinational terms are gated by rst).
- Latency:
  - fwd_*_sel are valid in the first cycle an instruction occupies EX (registered at the ID→EX edge).
  - stall and ex_bubble are combinational in the same cycle as the hazard.
- A load-use stall lasts exactly one cycle unless extended by mem_busy.
- Reset asserted mid-stall clears all slots at the next edge. No hazard survives reset.

## Structure

- Shared package `fwd_pkg`:
  - FWD_REG=2'd0, FWD_EXMEM=2'd1, FWD_MEMWB=2'd2.
  - Packed struct `stage_tag_t` {valid, rd, reg_write, mem_read}.
- One sub-module, `fwd_match`: combinational compare of one source against the EX and MEM tags, returning a select code. Instantiated twice (A, B).
- Slot registers and the stall logic live in the top module.

## Test plan

- Back-to-back ALU dependency:
  - `add x5` followed by `sub x6,x5,x7` → fwd_a_sel=1, fwd_b_sel=0 in the sub's EX cycle. No stall.
- Distance-2 dependency:
  - `add x5` followed by an unrelated instruction, then `or x8,x9,x5` → fwd_b_sel=2.
  - If x5 is also written in the middle instruction → fwd_b_sel=1 (priority check).
- Load-use:
  - `lw x3` followed by `add x4,x3,x3` → stall=1 and ex_bubble=1 for one cycle.
  - The add then enters EX with fwd_a_sel = fwd_b_sel = 2.
- x0 and unused sources:
  - `add x0` followed by `sub x1,x0,x0` → selects 0.
  - A dependent instruction with id_use_rs2=0 → fwd_b_sel=0.
- Load-use coinciding with ex_branch_taken → stall=0, ex_bubble=1, no load-use bubble.
- mem_busy for 3 cycles during a load-use:
  - Outputs and slots hold while frozen.
  - After release: exactly one bubble, then fwd_a_sel=2.
- Reset mid-stall → all outputs 0 the next cycle.
